// File: rtl/lfsr_stream_cipher_core.sv
// Multi-channel Galois-LFSR stream cipher: per-channel seedable keystream, OFB and
// ciphertext-autokey modes, valid/ready datapath with a single output register.
module lfsr_stream_cipher_core #(
  parameter int unsigned          WIDTH  = 8,
  parameter int unsigned          LFSR_W = 16,
  parameter logic [LFSR_W-1:0]    TAPS   = 16'hB400,
  parameter int unsigned          N_CH   = 4,
  parameter int unsigned          CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              key_start,
  input  logic [CH_W-1:0]   key_ch,
  input  logic              key_valid,
  input  logic [WIDTH-1:0]  key_data,
  output logic              key_busy,
  output logic [N_CH-1:0]   ch_loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_decrypt,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch
);

  localparam int unsigned BEATS = LFSR_W / WIDTH;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t             state;
  logic [LFSR_W-1:0]  lfsr [N_CH];
  logic [LFSR_W-1:0]  stage;
  logic [CNT_W-1:0]   cnt;
  logic [CH_W-1:0]    key_ch_q;

  logic [LFSR_W-1:0]  cur_s;
  logic [LFSR_W-1:0]  step_s;
  logic [LFSR_W-1:0]  stage_next;
  logic [LFSR_W-1:0]  seed_w;
  logic [WIDTH-1:0]   ks;
  logic [WIDTH-1:0]   y;
  logic               accept;
  logic               beat;
  logic               last_beat;

  // Keystream word, cipher result and next LFSR state for the selected channel
  always_comb begin
    cur_s      = lfsr[in_ch];
    ks         = cur_s[WIDTH-1:0];
    y          = in_data ^ ks;
    step_s     = (cur_s >> 1) ^ (cur_s[0] ? TAPS : '0);
    if (in_mode)
      step_s[WIDTH-1:0] = step_s[WIDTH-1:0] ^ (in_decrypt ? in_data : y);
    stage_next = (stage << WIDTH) | LFSR_W'(key_data);
    // An all-zero seed would lock the LFSR at zero forever
    seed_w     = (stage_next == '0) ? LFSR_W'(1) : stage_next;
    in_ready   = ena & (state == IDLE) & ch_loaded[in_ch] & (~out_valid | out_ready);
    accept     = in_valid & in_ready;
    beat       = ena & (state == LOAD) & key_valid;
    last_beat  = beat & (cnt == CNT_W'(BEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_busy  <= 1'b0;
      ch_loaded <= '0;
      stage     <= '0;
      cnt       <= '0;
      key_ch_q  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      for (int unsigned i = 0; i < N_CH; i++) lfsr[i] <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (key_start) begin
            state             <= LOAD;
            key_busy          <= 1'b1;
            key_ch_q          <= key_ch;
            cnt               <= '0;
            ch_loaded[key_ch] <= 1'b0;
          end
        end
        LOAD: begin
          if (beat) begin
            stage <= stage_next;
            if (last_beat) begin
              lfsr[key_ch_q]      <= seed_w;
              ch_loaded[key_ch_q] <= 1'b1;
              state               <= IDLE;
              key_busy            <= 1'b0;
              cnt                 <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Output register drains independently of the key-load FSM
      if (accept) begin
        lfsr[in_ch] <= step_s;
        out_valid   <= 1'b1;
        out_data    <= y;
        out_ch      <= in_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_cipher_core.sv
// Scoreboard bench for lfsr_stream_cipher_core: directed vectors, queue of expected
// {channel,data} results popped by an independent output monitor.
module tb_lfsr_stream_cipher_core;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CH_W  = 2;
  localparam int unsigned N_CH  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             key_start;
  logic [CH_W-1:0]  key_ch;
  logic             key_valid;
  logic [WIDTH-1:0] key_data;
  logic             key_busy;
  logic [N_CH-1:0]  ch_loaded;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CH_W-1:0]  in_ch;
  logic             in_decrypt;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CH_W-1:0]  out_ch;

  int checks = 0;
  int errors = 0;
  logic [CH_W+WIDTH-1:0] sb [$];

  always #5 clk = ~clk;

  lfsr_stream_cipher_core dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .key_start(key_start), .key_ch(key_ch), .key_valid(key_valid), .key_data(key_data),
    .key_busy(key_busy), .ch_loaded(ch_loaded),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .in_decrypt(in_decrypt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is compared against the queue head
  initial begin
    logic [CH_W+WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {out_ch, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e[WIDTH-1:0]);
          check("out_ch", out_ch, e[CH_W+WIDTH-1:WIDTH]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [CH_W-1:0] ch, input logic [15:0] seed,
                      output logic busy_seen, output logic [N_CH-1:0] loaded_seen);
    key_start = 1'b1;
    key_ch    = ch;
    tick();
    key_start   = 1'b0;
    busy_seen   = key_busy;
    loaded_seen = ch_loaded;
    key_valid = 1'b1; key_data = seed[15:8]; tick();
    key_data  = seed[7:0]; tick();
    key_valid = 1'b0;
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d,
                      input logic dec, input logic mode, input logic push,
                      input logic [WIDTH-1:0] exp);
    int n;
    if (push) sb.push_back({ch, exp});
    in_ch = ch; in_data = d; in_decrypt = dec; in_mode = mode; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic            bs;
    logic [N_CH-1:0] ls;
    rst_n = 1'b0; ena = 1'b1; key_start = 1'b0; key_ch = '0; key_valid = 1'b0;
    key_data = '0; in_valid = 1'b0; in_data = '0; in_ch = '0; in_decrypt = 1'b0;
    in_mode = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_ch_loaded", ch_loaded, 0);
    check("rst_key_busy", key_busy, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    // T1: seed 0xACE1, OFB encrypt
    load(2'd0, 16'hACE1, bs, ls);
    check("t1_busy_in_load", bs, 1);
    check("t1_loaded", ch_loaded, 4'b0001);
    send(2'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h1E);
    send(2'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h8F);
    drain();

    // T2: ch1 seeded, then ch0 reseeded and decrypted; ch1 must stay loaded
    load(2'd1, 16'h1234, bs, ls);
    load(2'd0, 16'hACE1, bs, ls);
    check("t2_ch0_dropped", ls[0], 0);
    check("t2_ch1_kept", ls[1], 1);
    check("t2_loaded", ch_loaded, 4'b0011);
    send(2'd0, 8'h1E, 1'b1, 1'b0, 1'b1, 8'hFF);
    send(2'd0, 8'h8F, 1'b1, 1'b0, 1'b1, 8'hFF);
    drain();

    // T3: CAK encrypt then decrypt must leave the same state (next k = 0x6E)
    load(2'd0, 16'hACE1, bs, ls);
    send(2'd0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h1E);
    send(2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h6E);
    load(2'd0, 16'hACE1, bs, ls);
    send(2'd0, 8'h1E, 1'b1, 1'b1, 1'b1, 8'hFF);
    send(2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h6E);
    drain();

    // T4: zero seed becomes 1; unloaded channel stalls
    load(2'd3, 16'h0000, bs, ls);
    send(2'd3, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01);
    drain();
    in_ch = 2'd2; in_data = 8'h55; in_valid = 1'b1;
    @(negedge clk);
    check("t4_unloaded_ready", in_ready, 0);
    tick();
    check("t4_unloaded_ready2", in_ready, 0);
    check("t4_no_output", out_valid, 0);
    in_valid = 1'b0;

    // T5: backpressure on ch1 (seed 0x1234 untouched since load)
    out_ready = 1'b0;
    sb.push_back({2'd1, 8'h34});
    sb.push_back({2'd1, 8'h1A});
    in_ch = 2'd1; in_data = 8'h00; in_decrypt = 1'b0; in_mode = 1'b0; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold_valid", out_valid, 1);
      check("t5_hold_data", out_data, 8'h34);
      check("t5_hold_ch", out_ch, 1);
      check("t5_in_ready", in_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();

    // T6: reset mid-load with a pending output
    out_ready = 1'b0;
    send(2'd1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    key_start = 1'b1; key_ch = 2'd2; tick();
    key_start = 1'b0;
    key_valid = 1'b1; key_data = 8'hAC; tick();
    key_valid = 1'b0;
    check("t6_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    check("t6_out_valid", out_valid, 0);
    check("t6_ch_loaded", ch_loaded, 0);
    check("t6_key_busy", key_busy, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    load(2'd2, 16'hACE1, bs, ls);
    check("t6_reload", ch_loaded, 4'b0100);
    send(2'd2, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h1E);
    drain();

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
